// File: rtl/pratica2_pkg.sv
// Shared definitions for the pratica2 multicycle processor control unit:
// instruction field positions, opcode constants and the control FSM state type.
package pratica2_pkg;

  // Instruction encoding III XXX YYY (opcode, Rx, Ry), each field 3 bits wide
  localparam int IR_OP_LSB = 6;
  localparam int IR_X_LSB  = 3;
  localparam int IR_Y_LSB  = 0;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOADIR,
    S_T1,
    S_T2,
    S_T3
  } state_e;

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable, used for the register load enables
// and register bus-driver selects.
//   en_i     : enable; all outputs 0 when low
//   sel_i    : register index 0..7
//   onehot_o : onehot_o[sel_i] = en_i, all other bits 0
module dec3to8 (
  input  logic       en_i,
  input  logic [2:0] sel_i,
  output logic [7:0] onehot_o
);

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign onehot_o[i] = en_i && (sel_i == 3'(i));
  end

endmodule

// File: rtl/pratica2_control.sv
// Control unit of the 16-bit pratica2 multicycle processor (R0-R6 general, R7 = PC).
// Sequences fetch / memory wait / IR load / execute steps T1..T3 and decodes the
// datapath strobes combinationally from (state, ir, g_nz).
//   clock, resetn : rising-edge clock, synchronous active-low reset
//   run           : start/continue; sampled in S_IDLE and in the done cycle only
//   ir, g_nz      : instruction register contents, G non-zero flag (mvnz)
//   irin          : load IR from din
//   rin, rout     : one-hot register load enables / bus drivers R0..R7
//   gout, dinout  : G / din drive the bus
//   ain, gin      : load A from bus / load G from ALU; addsub selects A-bus
//   incr_pc       : R7 <= R7 + 1
//   addr_in, dout_in, w_d : memory address load, data-out load, write enable
//   done          : one-cycle pulse in the last cycle of each instruction
module pratica2_control
  import pratica2_pkg::*;
#(
  parameter int IR_WIDTH    = 9,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                run,
  input  logic [IR_WIDTH-1:0] ir,
  input  logic                g_nz,
  output logic                irin,
  output logic [7:0]          rin,
  output logic [7:0]          rout,
  output logic                gout,
  output logic                dinout,
  output logic                ain,
  output logic                gin,
  output logic                addsub,
  output logic                incr_pc,
  output logic                addr_in,
  output logic                dout_in,
  output logic                w_d,
  output logic                done
);

  localparam int             CW        = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0]  WAIT_LAST = CW'(MEM_LATENCY - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op, rx, ry;
  logic          rin_en, rout_en;
  logic [2:0]    rout_sel;
  logic          wait_last;

  assign op        = ir[IR_OP_LSB +: 3];
  assign rx        = ir[IR_X_LSB +: 3];
  assign ry        = ir[IR_Y_LSB +: 3];
  assign wait_last = (cnt_q == WAIT_LAST);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_sel = ry;
    irin     = 1'b0;
    gout     = 1'b0;
    dinout   = 1'b0;
    ain      = 1'b0;
    gin      = 1'b0;
    addsub   = 1'b0;
    incr_pc  = 1'b0;
    addr_in  = 1'b0;
    dout_in  = 1'b0;
    w_d      = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        rout_en  = 1'b1;
        rout_sel = 3'd7;
        addr_in  = 1'b1;
        incr_pc  = 1'b1;
        state_d  = S_WAIT;
      end
      // counter runs 0..MEM_LATENCY-1, one cycle per count
      S_WAIT: begin
        if (wait_last) state_d = S_LOADIR;
        else           cnt_d   = cnt_q + 1'b1;
      end
      S_LOADIR: begin
        dinout  = 1'b1;
        irin    = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        case (op)
          OP_MV: begin
            rout_en = 1'b1;
            rin_en  = 1'b1;
            done    = 1'b1;
          end
          OP_MVI: begin
            rout_en  = 1'b1;
            rout_sel = 3'd7;
            addr_in  = 1'b1;
            incr_pc  = 1'b1;
            state_d  = S_T2;
          end
          OP_ADD, OP_SUB: begin
            rout_en  = 1'b1;
            rout_sel = rx;
            ain      = 1'b1;
            state_d  = S_T2;
          end
          OP_LD, OP_ST: begin
            rout_en = 1'b1;
            addr_in = 1'b1;
            state_d = S_T2;
          end
          OP_MVNZ: begin
            rout_en = g_nz;
            rin_en  = g_nz;
            done    = 1'b1;
          end
          OP_NOP:  done = 1'b1;
          default: done = 1'b1;
        endcase
      end
      S_T2: begin
        case (op)
          OP_MVI, OP_LD: begin
            if (wait_last) state_d = S_T3;
            else           cnt_d   = cnt_q + 1'b1;
          end
          OP_ADD, OP_SUB: begin
            rout_en = 1'b1;
            gin     = 1'b1;
            addsub  = (op == OP_SUB);
            state_d = S_T3;
          end
          OP_ST: begin
            rout_en  = 1'b1;
            rout_sel = rx;
            dout_in  = 1'b1;
            state_d  = S_T3;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_T3: begin
        case (op)
          OP_MVI, OP_LD: begin
            dinout = 1'b1;
            rin_en = 1'b1;
            done   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            gout   = 1'b1;
            rin_en = 1'b1;
            done   = 1'b1;
          end
          OP_ST: begin
            w_d  = 1'b1;
            done = 1'b1;
          end
          default: state_d = S_IDLE;
        endcase
      end
      default: state_d = S_IDLE;
    endcase

    if (done) state_d = run ? S_FETCH : S_IDLE;

    // outputs are forced quiet for as long as reset is held, not just after the edge
    if (!resetn) begin
      rin_en  = 1'b0;
      rout_en = 1'b0;
      irin    = 1'b0;
      gout    = 1'b0;
      dinout  = 1'b0;
      ain     = 1'b0;
      gin     = 1'b0;
      addsub  = 1'b0;
      incr_pc = 1'b0;
      addr_in = 1'b0;
      dout_in = 1'b0;
      w_d     = 1'b0;
      done    = 1'b0;
    end
  end

  dec3to8 u_rin_dec (
    .en_i     (rin_en),
    .sel_i    (rx),
    .onehot_o (rin)
  );

  dec3to8 u_rout_dec (
    .en_i     (rout_en),
    .sel_i    (rout_sel),
    .onehot_o (rout)
  );

endmodule
